// File: rtl/dma_fifo_param.sv
// Parametrised DMA-side word FIFO in front of an external async-read RAM.
// Supports fill level, almost thresholds, frame-pulse flush, full pass-through and sticky error flags.
module dma_fifo_param #(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 5,
   parameter int AF_THRESH   = 28,
   parameter int AE_THRESH   = 4,
   parameter int FLUSH_ON_FP = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic [DATA_W-1:0] data_in,
   input  logic              pull,
   output logic [DATA_W-1:0] data_out,
   input  logic              fp_pulse,
   input  logic              clr_err,
   output logic              full,
   output logic              empty,
   output logic              almost_full,
   output logic              almost_empty,
   output logic [ADDR_W:0]   level,
   output logic [ADDR_W:0]   depth_left,
   output logic              ovf,
   output logic              udf,
   output logic [ADDR_W-1:0] mem_waddr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_raddr,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int            DEPTH    = 2 ** ADDR_W;
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W:0] AF_L    = (ADDR_W + 1)'(AF_THRESH);
   localparam logic [ADDR_W:0] AE_L    = (ADDR_W + 1)'(AE_THRESH);
   localparam logic          FLUSH_EN = (FLUSH_ON_FP != 0);

   logic [ADDR_W-1:0] w_ptr_q, w_ptr_d;
   logic [ADDR_W-1:0] r_ptr_q, r_ptr_d;
   logic [ADDR_W:0]   level_q, level_d;
   logic              ovf_q, ovf_d;
   logic              udf_q, udf_d;

   logic flush;
   logic empty_w;
   logic full_w;
   logic pull_ok;
   logic push_ok;

   always_comb begin
      flush   = fp_pulse & FLUSH_EN;
      empty_w = (level_q == '0);
      full_w  = (level_q == DEPTH_L);
      pull_ok = pull & ~empty_w & ~flush;
      // When full, a same-cycle pull frees the slot being written (pass-through).
      push_ok = push & ~flush & (~full_w | pull_ok);

      w_ptr_d = w_ptr_q;
      r_ptr_d = r_ptr_q;
      level_d = level_q;
      if (flush) begin
         w_ptr_d = '0;
         r_ptr_d = '0;
         level_d = '0;
      end else begin
         if (push_ok) w_ptr_d = w_ptr_q + 1'b1;
         if (pull_ok) r_ptr_d = r_ptr_q + 1'b1;
         case ({push_ok, pull_ok})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
         endcase
      end

      // A new error in the same cycle as clr_err wins over the clear.
      ovf_d = (push & ~flush & ~push_ok) | (ovf_q & ~clr_err);
      udf_d = (pull & empty_w & ~flush) | (udf_q & ~clr_err);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_ptr_q <= '0;
         r_ptr_q <= '0;
         level_q <= '0;
         ovf_q   <= 1'b0;
         udf_q   <= 1'b0;
      end else begin
         w_ptr_q <= w_ptr_d;
         r_ptr_q <= r_ptr_d;
         level_q <= level_d;
         ovf_q   <= ovf_d;
         udf_q   <= udf_d;
      end
   end

   always_comb begin
      full         = full_w;
      empty        = empty_w;
      almost_full  = (level_q >= AF_L);
      almost_empty = (level_q <= AE_L);
      level        = level_q;
      depth_left   = DEPTH_L - level_q;
      ovf          = ovf_q;
      udf          = udf_q;
      mem_waddr    = w_ptr_q;
      mem_wdata    = data_in;
      // Keep the RAM strobe quiet while reset is held.
      mem_we       = push_ok & rst_n;
      mem_raddr    = r_ptr_q;
      data_out     = empty_w ? '0 : mem_rdata;
   end

endmodule

// File: tb/tb_dma_fifo_param.sv
// Bench for dma_fifo_param: vector table, directed corner sequences and random traffic
// compared against a queue-based reference model.
module tb_dma_fifo_param;

   localparam int DW    = 32;
   localparam int AW    = 5;
   localparam int DEPTH = 32;

   logic          clk;
   logic          rst_n;
   logic          push, pull, fp_pulse, clr_err;
   logic [DW-1:0] data_in;

   logic [DW-1:0] data_out, mem_wdata, mem_rdata;
   logic          full, empty, almost_full, almost_empty, ovf, udf, mem_we;
   logic [AW:0]   level, depth_left;
   logic [AW-1:0] mem_waddr, mem_raddr;

   logic [DW-1:0] nf_data_out, nf_mem_wdata, nf_mem_rdata;
   logic          nf_full, nf_empty, nf_af, nf_ae, nf_ovf, nf_udf, nf_mem_we;
   logic [AW:0]   nf_level, nf_depth_left;
   logic [AW-1:0] nf_mem_waddr, nf_mem_raddr;

   logic [DW-1:0] ram    [DEPTH];
   logic [DW-1:0] ram_nf [DEPTH];

   int checks   = 0;
   int failures = 0;

   // reference model
   logic [DW-1:0] mq[$];
   int            m_w, m_r;
   bit            m_ovf, m_udf;

   typedef struct {
      bit            push, pull, fp, clr;
      logic [DW-1:0] din;
      int            e_level;
      logic [DW-1:0] e_dout;
      bit            e_we;
      bit            e_udf;
   } vec_t;
   vec_t vt[10];

   dma_fifo_param u_dut (
      .clk(clk), .rst_n(rst_n), .push(push), .data_in(data_in), .pull(pull),
      .data_out(data_out), .fp_pulse(fp_pulse), .clr_err(clr_err), .full(full),
      .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
      .level(level), .depth_left(depth_left), .ovf(ovf), .udf(udf),
      .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_we(mem_we),
      .mem_raddr(mem_raddr), .mem_rdata(mem_rdata)
   );

   dma_fifo_param #(.FLUSH_ON_FP(0)) u_dut_nf (
      .clk(clk), .rst_n(rst_n), .push(push), .data_in(data_in), .pull(pull),
      .data_out(nf_data_out), .fp_pulse(fp_pulse), .clr_err(clr_err), .full(nf_full),
      .empty(nf_empty), .almost_full(nf_af), .almost_empty(nf_ae),
      .level(nf_level), .depth_left(nf_depth_left), .ovf(nf_ovf), .udf(nf_udf),
      .mem_waddr(nf_mem_waddr), .mem_wdata(nf_mem_wdata), .mem_we(nf_mem_we),
      .mem_raddr(nf_mem_raddr), .mem_rdata(nf_mem_rdata)
   );

   always @(posedge clk) if (mem_we) ram[mem_waddr] <= mem_wdata;
   always @(posedge clk) if (nf_mem_we) ram_nf[nf_mem_waddr] <= nf_mem_wdata;
   assign mem_rdata    = ram[mem_raddr];
   assign nf_mem_rdata = ram_nf[nf_mem_raddr];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_w   = 0;
      m_r   = 0;
      m_ovf = 0;
      m_udf = 0;
   endtask

   // Compare every output against the model (pre-edge view), then advance the model.
   task automatic cycle(input bit p, input bit pl, input bit f, input bit c, input logic [DW-1:0] d);
      bit pok, wok, set_o, set_u;
      int sz;
      @(negedge clk);
      push = p; pull = pl; fp_pulse = f; clr_err = c; data_in = d;
      #1;
      sz    = mq.size();
      pok   = !f && pl && sz > 0;
      wok   = !f && p && (sz < DEPTH || pok);
      set_o = !f && p && !wok;
      set_u = !f && pl && sz == 0;
      check("level", level, DW'(sz));
      check("depth_left", depth_left, DW'(DEPTH - sz));
      check("empty", empty, DW'(sz == 0));
      check("full", full, DW'(sz == DEPTH));
      check("almost_full", almost_full, DW'(sz >= 28));
      check("almost_empty", almost_empty, DW'(sz <= 4));
      check("data_out", data_out, (sz > 0) ? mq[0] : '0);
      check("ovf", ovf, DW'(m_ovf));
      check("udf", udf, DW'(m_udf));
      check("mem_we", mem_we, DW'(wok));
      check("mem_waddr", mem_waddr, DW'(m_w));
      check("mem_raddr", mem_raddr, DW'(m_r));
      check("mem_wdata", mem_wdata, d);
      if (f) begin
         mq.delete();
         m_w = 0;
         m_r = 0;
      end else begin
         if (pok) begin
            void'(mq.pop_front());
            m_r = (m_r + 1) % DEPTH;
         end
         if (wok) begin
            mq.push_back(d);
            m_w = (m_w + 1) % DEPTH;
         end
      end
      m_ovf = set_o | (m_ovf & !c);
      m_udf = set_u | (m_udf & !c);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      push = 0; pull = 0; fp_pulse = 0; clr_err = 0; data_in = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_level"}, level, 0);
      check({tag, "_depth_left"}, depth_left, DEPTH);
      check({tag, "_empty"}, empty, 1);
      check({tag, "_full"}, full, 0);
      check({tag, "_ae"}, almost_empty, 1);
      check({tag, "_af"}, almost_full, 0);
      check({tag, "_ovf"}, ovf, 0);
      check({tag, "_udf"}, udf, 0);
      check({tag, "_mem_we"}, mem_we, 0);
      check({tag, "_data_out"}, data_out, 0);
      check({tag, "_waddr"}, mem_waddr, 0);
      check({tag, "_raddr"}, mem_raddr, 0);
   endtask

   initial begin
      rst_n = 1'b0;
      push = 0; pull = 0; fp_pulse = 0; clr_err = 0; data_in = '0;

      vt[0] = '{0, 0, 0, 0, 32'h00, 0, 32'h00, 0, 0};
      vt[1] = '{0, 1, 0, 0, 32'h00, 0, 32'h00, 0, 0};
      vt[2] = '{1, 0, 0, 0, 32'h11, 0, 32'h00, 1, 1};
      vt[3] = '{1, 0, 0, 0, 32'h22, 1, 32'h11, 1, 1};
      vt[4] = '{0, 0, 0, 1, 32'h00, 2, 32'h11, 0, 1};
      vt[5] = '{0, 1, 0, 0, 32'h00, 2, 32'h11, 0, 0};
      vt[6] = '{1, 1, 0, 0, 32'h33, 1, 32'h22, 1, 0};
      vt[7] = '{1, 0, 1, 0, 32'h44, 1, 32'h33, 0, 0};
      vt[8] = '{1, 1, 0, 0, 32'h55, 0, 32'h00, 1, 0};
      vt[9] = '{0, 0, 0, 0, 32'h00, 1, 32'h55, 0, 1};

      #3;
      check_reset_values("reset");
      do_reset();

      for (int i = 0; i < 10; i++) begin
         cycle(vt[i].push, vt[i].pull, vt[i].fp, vt[i].clr, vt[i].din);
         check($sformatf("vec%0d_level", i), level, DW'(vt[i].e_level));
         check($sformatf("vec%0d_dout", i), data_out, vt[i].e_dout);
         check($sformatf("vec%0d_we", i), mem_we, DW'(vt[i].e_we));
         check($sformatf("vec%0d_udf", i), udf, DW'(vt[i].e_udf));
      end

      // 1: fill to full, then overflow
      do_reset();
      for (int i = 0; i < 32; i++) begin
         cycle(1, 0, 0, 0, DW'(i));
         if (i == 27) begin
            cycle(0, 0, 0, 0, '0);
            check("t1_af_after_28", almost_full, 1);
         end
      end
      cycle(1, 0, 0, 0, 32'hDEAD);
      check("t1_level_full", level, 32);
      check("t1_full", full, 1);
      check("t1_depth_left", depth_left, 0);
      check("t1_we_on_33rd", mem_we, 0);
      cycle(0, 0, 0, 0, '0);
      check("t1_ovf", ovf, 1);

      // 2: drain in order, then underflow
      for (int i = 0; i < 32; i++) begin
         cycle(0, 1, 0, 0, '0);
         check("t2_order", data_out, DW'(i));
      end
      cycle(0, 1, 0, 0, '0);
      check("t2_empty", empty, 1);
      check("t2_raddr_before", mem_raddr, 0);
      cycle(0, 0, 0, 0, '0);
      check("t2_udf", udf, 1);
      check("t2_raddr_unchanged", mem_raddr, 0);

      // 3: pass-through at full
      cycle(0, 0, 0, 1, '0);
      for (int i = 0; i < 32; i++) cycle(1, 0, 0, 0, DW'(100 + i));
      cycle(1, 1, 0, 0, 32'hAA);
      check("t3_old_head", data_out, 100);
      check("t3_we", mem_we, 1);
      cycle(0, 0, 0, 0, '0);
      check("t3_level", level, 32);
      check("t3_no_ovf", ovf, 0);
      for (int i = 0; i < 31; i++) cycle(0, 1, 0, 0, '0);
      cycle(0, 0, 0, 0, '0);
      check("t3_tail", data_out, 32'hAA);

      // 4: steady level 3 with wrapping pointers
      while (mq.size() > 0) cycle(0, 1, 0, 0, '0);
      for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, DW'(200 + i));
      for (int i = 0; i < 40; i++) cycle(1, 1, 0, 0, DW'(300 + i));
      cycle(0, 0, 0, 0, '0);
      check("t4_level", level, 3);
      check("t4_head", data_out, DW'(337));

      // 5: frame-pulse flush vs ignored
      do_reset();
      for (int i = 0; i < 10; i++) cycle(1, 0, 0, 0, DW'(i));
      cycle(1, 0, 1, 0, 32'h77);
      check("t5_we_flush", mem_we, 0);
      cycle(0, 0, 0, 0, '0);
      check("t5_level", level, 0);
      check("t5_empty", empty, 1);
      check("t5_waddr", mem_waddr, 0);
      check("t5_ovf", ovf, 0);
      check("t5_nf_level", nf_level, 11);
      check("t5_nf_ovf", nf_ovf, 0);

      // 6: async reset mid-stream, then clr_err
      do_reset();
      for (int i = 0; i < 17; i++) cycle(1, 0, 0, 0, DW'(i));
      cycle(0, 0, 0, 0, '0);
      check("t6_level17", level, 17);
      rst_n = 1'b0;
      #1;
      check_reset_values("t6_async");
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 33; i++) cycle(1, 0, 0, 0, DW'(i));
      cycle(0, 0, 0, 1, '0);
      check("t6_ovf_set", ovf, 1);
      cycle(0, 0, 0, 0, '0);
      check("t6_ovf_cleared", ovf, 0);

      // random traffic against the model
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         int bias;
         bias = (i / 500) % 3;
         cycle($urandom_range(0, 9) < (bias == 0 ? 7 : (bias == 1 ? 3 : 5)),
               $urandom_range(0, 9) < (bias == 0 ? 3 : (bias == 1 ? 7 : 5)),
               $urandom_range(0, 99) == 0,
               $urandom_range(0, 19) == 0,
               $urandom());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
